// File: rtl/test_unit_chain_monitor.sv
// test_unit_chain_monitor
//   Watches the to_down_pass levels of a daisy chain of test units and turns
//   them into one registered verdict: units must pass in index order, a pass
//   must never drop once given, and each advance must arrive within
//   TIMEOUT_CYCLES (0 disables the timeout).
//   Optional build macro TEST_UNIT_CHAIN_MON_SYNC_EN: routes unit_pass through
//   a 2-flop synchronizer per bit, adding 2 cycles to every pass response.
//
//   Handshake: chain_start is a single-cycle pulse accepted only outside RUN;
//   unit_pass is a level bus; adv_pulse is a one-cycle strobe qualifying
//   unit_cycles; chain_done/chain_fail are sticky until chain_start or reset.
module test_unit_chain_monitor #(
   parameter  int NUM_UNITS      = 2,
   parameter  int TIMEOUT_CYCLES = 100000,
   parameter  int CNT_W          = 32,
   localparam int IDX_W          = $clog2(NUM_UNITS + 1)
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic                 chain_start,
   input  logic [NUM_UNITS-1:0] unit_pass,
   output logic                 chain_busy,
   output logic                 chain_done,
   output logic                 chain_fail,
   output logic [1:0]           fail_code,
   output logic [IDX_W-1:0]     fail_idx,
   output logic [IDX_W-1:0]     cur_idx,
   output logic                 adv_pulse,
   output logic [CNT_W-1:0]     unit_cycles,
   output logic [CNT_W-1:0]     total_cycles
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_FAIL} state_t;

   localparam logic [1:0]       CODE_NONE    = 2'd0;
   localparam logic [1:0]       CODE_ORDER   = 2'd1;
   localparam logic [1:0]       CODE_DROP    = 2'd2;
   localparam logic [1:0]       CODE_TIMEOUT = 2'd3;
   localparam logic [CNT_W-1:0] TO_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_ALL      = IDX_W'(NUM_UNITS);

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [NUM_UNITS-1:0] pass_s;

`ifdef TEST_UNIT_CHAIN_MON_SYNC_EN
   logic [NUM_UNITS-1:0] sync_1;
   logic [NUM_UNITS-1:0] sync_2;

   // Two-flop synchronizer per pass bit; cleared so a reset never shows stale passes.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= unit_pass;
         sync_2 <= sync_1;
      end
   end
   assign pass_s = sync_2;
`else
   assign pass_s = unit_pass;
`endif

   logic [IDX_W-1:0] prefix;
   logic [IDX_W-1:0] hole_idx;
   logic             hole;
   logic             gap_seen;

   // Length of the contiguous run of passes from unit 0, and the lowest pass above it.
   always_comb begin
      prefix   = '0;
      hole_idx = '0;
      hole     = 1'b0;
      gap_seen = 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (!gap_seen) begin
            if (pass_s[i]) prefix = prefix + IDX_W'(1);
            else           gap_seen = 1'b1;
         end else if (pass_s[i] && !hole) begin
            hole     = 1'b1;
            hole_idx = IDX_W'(i);
         end
      end
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] unit_cnt, unit_cnt_d;
   logic [CNT_W-1:0] unit_cycles_d, total_cycles_d;
   logic [IDX_W-1:0] cur_idx_d, fail_idx_d;
   logic [1:0]       fail_code_d;
   logic             adv_d;

   // Next-state and datapath rules; checks are applied only while in RUN.
   always_comb begin
      state_d        = state_q;
      unit_cnt_d     = unit_cnt;
      unit_cycles_d  = unit_cycles;
      total_cycles_d = total_cycles;
      cur_idx_d      = cur_idx;
      fail_idx_d     = fail_idx;
      fail_code_d    = fail_code;
      adv_d          = 1'b0;
      case (state_q)
         ST_RUN: begin
            total_cycles_d = sat_inc(total_cycles);
            if (hole) begin
               state_d     = ST_FAIL;
               fail_code_d = CODE_ORDER;
               fail_idx_d  = hole_idx;
            end else if (prefix < cur_idx) begin
               state_d     = ST_FAIL;
               fail_code_d = CODE_DROP;
               fail_idx_d  = prefix;
            end else if (prefix > cur_idx) begin
               // Several units rising together still count as one advance.
               adv_d         = 1'b1;
               cur_idx_d     = prefix;
               unit_cycles_d = sat_inc(unit_cnt);
               unit_cnt_d    = '0;
               if (prefix == IDX_ALL) state_d = ST_DONE;
            end else if ((TIMEOUT_CYCLES != 0) && (unit_cnt == TO_LAST)) begin
               state_d     = ST_FAIL;
               fail_code_d = CODE_TIMEOUT;
               fail_idx_d  = cur_idx;
            end else begin
               unit_cnt_d = sat_inc(unit_cnt);
            end
         end
         default: begin
            // IDLE, DONE and FAIL all re-arm on a start pulse.
            if (chain_start) begin
               state_d        = ST_RUN;
               unit_cnt_d     = '0;
               unit_cycles_d  = '0;
               total_cycles_d = '0;
               cur_idx_d      = '0;
               fail_idx_d     = '0;
               fail_code_d    = CODE_NONE;
            end
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Registered outputs and counters; status flags are decoded from the next state.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         unit_cnt     <= '0;
         unit_cycles  <= '0;
         total_cycles <= '0;
         cur_idx      <= '0;
         fail_idx     <= '0;
         fail_code    <= CODE_NONE;
         adv_pulse    <= 1'b0;
         chain_busy   <= 1'b0;
         chain_done   <= 1'b0;
         chain_fail   <= 1'b0;
      end else begin
         unit_cnt     <= unit_cnt_d;
         unit_cycles  <= unit_cycles_d;
         total_cycles <= total_cycles_d;
         cur_idx      <= cur_idx_d;
         fail_idx     <= fail_idx_d;
         fail_code    <= fail_code_d;
         adv_pulse    <= adv_d;
         chain_busy   <= (state_d == ST_RUN);
         chain_done   <= (state_d == ST_DONE);
         chain_fail   <= (state_d == ST_FAIL);
      end
   end

endmodule

// File: tb/tb_test_unit_chain_monitor.sv
// tb_test_unit_chain_monitor
//   Directed scenarios with fixed expectations, then randomized pass traffic
//   compared every cycle against a behavioural model of the chain rules.
//   Honours TEST_UNIT_CHAIN_MON_SYNC_EN by adding the synchronizer latency.
module tb_test_unit_chain_monitor;

   localparam int N   = 2;
   localparam int TO  = 50;
   localparam int CW  = 6;
   localparam int IW  = $clog2(N + 1);
   localparam int SAT = (1 << CW) - 1;
`ifdef TEST_UNIT_CHAIN_MON_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          clock       = 1'b0;
   logic          rst_n       = 1'b1;
   logic          chain_start = 1'b0;
   logic [N-1:0]  unit_pass   = '0;
   logic          chain_busy, chain_done, chain_fail, adv_pulse;
   logic [1:0]    fail_code;
   logic [IW-1:0] fail_idx, cur_idx;
   logic [CW-1:0] unit_cycles, total_cycles;

   always #5 clock = ~clock;

   test_unit_chain_monitor #(
      .NUM_UNITS      (N),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .chain_start  (chain_start),
      .unit_pass    (unit_pass),
      .chain_busy   (chain_busy),
      .chain_done   (chain_done),
      .chain_fail   (chain_fail),
      .fail_code    (fail_code),
      .fail_idx     (fail_idx),
      .cur_idx      (cur_idx),
      .adv_pulse    (adv_pulse),
      .unit_cycles  (unit_cycles),
      .total_cycles (total_cycles)
   );

   int total_n = 0;
   int bad_n   = 0;

   // ---------------- behavioural reference model ----------------
   // m_st: 0 idle, 1 running, 2 done, 3 failed
   int            m_st, m_cur, m_ucnt, m_ucyc, m_total, m_code, m_fidx;
   bit            m_adv;
   logic [N-1:0]  hist[$];
   logic [CW-1:0] exp_q[$];

   function automatic int sat(input int v);
      return (v > SAT) ? SAT : v;
   endfunction

   function automatic int prefix_of(input logic [N-1:0] p);
      int n = 0;
      while (n < N && p[n] === 1'b1) n++;
      return n;
   endfunction

   function automatic int hole_of(input logic [N-1:0] p, input int pre);
      for (int i = pre + 1; i < N; i++) if (p[i] === 1'b1) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_st = 0; m_cur = 0; m_ucnt = 0; m_ucyc = 0; m_total = 0;
      m_code = 0; m_fidx = 0; m_adv = 0;
      hist.delete();
      for (int i = 0; i < LAT; i++) hist.push_back('0);
   endtask

   task automatic model_edge(input bit st, input logic [N-1:0] pass);
      logic [N-1:0] seen;
      int pre, h;
      hist.push_back(pass);
      seen  = hist.pop_front();
      m_adv = 0;
      if (m_st != 1) begin
         if (st) begin
            m_st = 1; m_cur = 0; m_ucnt = 0; m_ucyc = 0; m_total = 0; m_code = 0; m_fidx = 0;
         end
      end else begin
         m_total = sat(m_total + 1);
         pre = prefix_of(seen);
         h   = hole_of(seen, pre);
         if (h >= 0) begin
            m_st = 3; m_code = 1; m_fidx = h;
         end else if (pre < m_cur) begin
            m_st = 3; m_code = 2; m_fidx = pre;
         end else if (pre > m_cur) begin
            m_adv = 1; m_ucyc = sat(m_ucnt + 1); m_ucnt = 0; m_cur = pre;
            exp_q.push_back(CW'(m_ucyc));
            if (pre == N) m_st = 2;
         end else if (TO != 0 && m_ucnt == TO - 1) begin
            m_st = 3; m_code = 3; m_fidx = m_cur;
         end else begin
            m_ucnt = sat(m_ucnt + 1);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input bit st, input logic [N-1:0] pass);
      chain_start = st;
      unit_pass   = pass;
      @(posedge clock);
      model_edge(st, pass);
      #1;
   endtask

   task automatic do_reset();
      chain_start = 1'b0;
      unit_pass   = '0;
      rst_n       = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;
   endtask

   // Flushes any old pass levels through the synchronizer, then pulses start.
   task automatic start_run();
      repeat (LAT + 1) tick(1'b0, '0);
      tick(1'b1, '0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      total_n++;
      if ({chain_busy, chain_done, chain_fail, adv_pulse} !== 4'b0) begin
         bad_n++; $display("FAIL reset_flags got=%b want=0000", {chain_busy, chain_done, chain_fail, adv_pulse});
      end
      total_n++;
      if ({fail_code, fail_idx, cur_idx} !== '0) begin
         bad_n++; $display("FAIL reset_idx got code=%0d fidx=%0d cur=%0d want 0", fail_code, fail_idx, cur_idx);
      end
      total_n++;
      if ({unit_cycles, total_cycles} !== '0) begin
         bad_n++; $display("FAIL reset_cnt got ucyc=%0d total=%0d want 0", unit_cycles, total_cycles);
      end
   endtask

   task automatic test_in_order();
      logic [CW-1:0] want_q[$];
      logic [CW-1:0] w;
      int n_adv = 0, first_k = -1;
      want_q.push_back(CW'(10 + LAT));
      want_q.push_back(CW'(15));
      start_run();
      total_n++;
      if (chain_busy !== 1'b1) begin
         bad_n++; $display("FAIL order_busy got=%b want=1", chain_busy);
      end
      for (int k = 1; k <= 40; k++) begin
         tick(1'b0, (k >= 25) ? 2'b11 : (k >= 10) ? 2'b01 : 2'b00);
         if (adv_pulse === 1'b1) begin
            n_adv++;
            if (first_k < 0) first_k = k;
            total_n++;
            if (want_q.size() == 0) begin
               bad_n++; $display("FAIL order_extra_adv k=%0d got ucyc=%0d want no pulse", k, unit_cycles);
            end else begin
               w = want_q.pop_front();
               if (unit_cycles !== w) begin
                  bad_n++; $display("FAIL order_ucyc got=%0d want=%0d", unit_cycles, w);
               end
            end
         end
      end
      total_n++;
      if (n_adv !== 2 || first_k !== 10 + LAT) begin
         bad_n++; $display("FAIL order_adv got n=%0d first=%0d want n=2 first=%0d", n_adv, first_k, 10 + LAT);
      end
      total_n++;
      if ({chain_done, chain_fail, chain_busy, fail_code} !== 5'b10000 || cur_idx !== IW'(2)) begin
         bad_n++; $display("FAIL order_verdict got d=%b f=%b b=%b code=%0d cur=%0d want 1 0 0 0 2",
                           chain_done, chain_fail, chain_busy, fail_code, cur_idx);
      end
      total_n++;
      if (total_cycles !== CW'(25 + LAT)) begin
         bad_n++; $display("FAIL order_total got=%0d want=%0d", total_cycles, 25 + LAT);
      end
   endtask

   task automatic test_same_cycle();
      int n_adv = 0;
      start_run();
      for (int k = 1; k <= 20; k++) begin
         // start pulse inside RUN must not restart counting
         tick(k == 2, (k >= 5) ? 2'b11 : 2'b00);
         if (adv_pulse === 1'b1) n_adv++;
      end
      total_n++;
      if (n_adv !== 1 || cur_idx !== IW'(2) || chain_done !== 1'b1) begin
         bad_n++; $display("FAIL same_cycle got n=%0d cur=%0d done=%b want 1 2 1", n_adv, cur_idx, chain_done);
      end
      total_n++;
      if (unit_cycles !== CW'(5 + LAT) || total_cycles !== CW'(5 + LAT)) begin
         bad_n++; $display("FAIL same_cycle_cnt got ucyc=%0d total=%0d want %0d", unit_cycles, total_cycles, 5 + LAT);
      end
   endtask

   task automatic test_order_fail();
      start_run();
      for (int k = 1; k <= 15; k++) tick(1'b0, (k >= 3) ? 2'b10 : 2'b00);
      total_n++;
      if ({chain_fail, chain_done, chain_busy} !== 3'b100 || fail_code !== 2'd1 || fail_idx !== IW'(1)) begin
         bad_n++; $display("FAIL order_rule got f=%b d=%b b=%b code=%0d idx=%0d want 1 0 0 1 1",
                           chain_fail, chain_done, chain_busy, fail_code, fail_idx);
      end
   endtask

   task automatic test_timeout();
      int fail_k = -1;
      start_run();
      for (int k = 1; k <= 100; k++) begin
         tick(1'b0, '0);
         if (chain_fail === 1'b1 && fail_k < 0) fail_k = k;
      end
      total_n++;
      if (fail_k !== TO) begin
         bad_n++; $display("FAIL timeout_time got=%0d want=%0d", fail_k, TO);
      end
      total_n++;
      if (fail_code !== 2'd3 || fail_idx !== IW'(0) || total_cycles !== CW'(TO)) begin
         bad_n++; $display("FAIL timeout_code got code=%0d idx=%0d total=%0d want 3 0 %0d", fail_code, fail_idx, total_cycles, TO);
      end
   endtask

   task automatic test_drop();
      start_run();
      for (int k = 1; k <= 20; k++) tick(1'b0, (k >= 5 && k <= 7) ? 2'b01 : 2'b00);
      total_n++;
      if (chain_fail !== 1'b1 || fail_code !== 2'd2 || fail_idx !== IW'(0) || cur_idx !== IW'(1)) begin
         bad_n++; $display("FAIL drop got f=%b code=%0d idx=%0d cur=%0d want 1 2 0 1", chain_fail, fail_code, fail_idx, cur_idx);
      end
   endtask

   task automatic test_reset_mid_run();
      start_run();
      for (int k = 1; k <= 12; k++) tick(1'b0, (k >= 5) ? 2'b01 : 2'b00);
      total_n++;
      if (cur_idx !== IW'(1) || chain_busy !== 1'b1) begin
         bad_n++; $display("FAIL mid_pre got cur=%0d busy=%b want 1 1", cur_idx, chain_busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total_n++;
      if ({chain_busy, chain_done, chain_fail, adv_pulse, fail_code, fail_idx, cur_idx, unit_cycles, total_cycles} !== '0) begin
         bad_n++; $display("FAIL mid_async got busy=%b cur=%0d total=%0d want all 0", chain_busy, cur_idx, total_cycles);
      end
      do_reset();
      start_run();
      for (int k = 1; k <= 20; k++) tick(1'b0, (k >= 7) ? 2'b11 : (k >= 3) ? 2'b01 : 2'b00);
      total_n++;
      if (chain_done !== 1'b1 || chain_fail !== 1'b0 || cur_idx !== IW'(2)) begin
         bad_n++; $display("FAIL mid_rerun got d=%b f=%b cur=%0d want 1 0 2", chain_done, chain_fail, cur_idx);
      end
   endtask

   task automatic test_saturation();
      start_run();
      for (int k = 1; k <= 90; k++) tick(1'b0, (k >= 80) ? 2'b11 : (k >= 40) ? 2'b01 : 2'b00);
      total_n++;
      if (chain_done !== 1'b1 || unit_cycles !== CW'(40) || total_cycles !== CW'(SAT)) begin
         bad_n++; $display("FAIL saturate got d=%b ucyc=%0d total=%0d want 1 40 %0d", chain_done, unit_cycles, total_cycles, SAT);
      end
   endtask

   task automatic test_random();
      int lvl, adv_div, b;
      logic [N-1:0]  pv;
      logic [CW-1:0] w;
      logic [9:0]    obs, want;
      exp_q.delete();
      for (int run = 0; run < 6; run++) begin
         adv_div = $urandom_range(4, 40);
         lvl = 0;
         start_run();
         for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, adv_div - 1) == 0 && lvl < N) lvl++;
            else if ($urandom_range(0, 59) == 0 && lvl > 0) lvl--;
            pv = N'((1 << lvl) - 1);
            if ($urandom_range(0, 79) == 0) begin
               b = $urandom_range(0, N - 1);
               pv[b] = ~pv[b];
            end
            tick($urandom_range(0, 59) == 0, pv);
            obs  = {chain_busy, chain_done, chain_fail, fail_code, fail_idx, cur_idx, adv_pulse};
            want = {m_st == 1, m_st == 2, m_st == 3, 2'(m_code), IW'(m_fidx), IW'(m_cur), m_adv};
            total_n++;
            if (obs !== want) begin
               bad_n++; $display("FAIL rnd_status run=%0d k=%0d got=%b want=%b", run, k, obs, want);
            end
            total_n++;
            if (total_cycles !== CW'(m_total)) begin
               bad_n++; $display("FAIL rnd_total run=%0d k=%0d got=%0d want=%0d", run, k, total_cycles, m_total);
            end
            if (m_adv) begin
               w = exp_q.pop_front();
               total_n++;
               if (unit_cycles !== w) begin
                  bad_n++; $display("FAIL rnd_ucyc run=%0d k=%0d got=%0d want=%0d", run, k, unit_cycles, w);
               end
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_in_order();
      test_same_cycle();
      test_order_fail();
      test_timeout();
      test_drop();
      test_reset_mid_run();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total_n, bad_n);
      $fatal(1, "watchdog");
   end

endmodule
